sd_init_sequencer: RTL and testbench

//  Drives the SD command controller through card identification/initialisation after power-up.

---
 rtl/sd_init_sequencer.sv | 138 +++++++++++++
 tb/tb_sd_init_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sd_init_sequencer.sv
// sd_init_sequencer: SD card identification/initialisation sequencer; CMD9/CSD read enabled by SD_INIT_CSD_EN
module sd_init_sequencer #(
  parameter int unsigned POWERUP_CYCLES = 80,
  parameter int unsigned GAP_CYCLES = 8,
  parameter int unsigned ACMD41_RETRIES = 1000
) (
  input  logic         sdClock,
  input  logic         reset,
  input  logic         beginInit,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [3:0]   errorCode,
  output logic         highCapacity,
  output logic [31:0]  ocr,
  output logic [15:0]  rca,
  output logic [119:0] csd,
  output logic         cmdStart,
  output logic [5:0]   cmdIndex,
  output logic [31:0]  cmdArgument,
  input  logic         cmdFinished,
  input  logic         cmdTimeout,
  input  logic [5:0]   cmdRespIndex,
  input  logic [119:0] cmdRespArgument
);
  typedef enum logic [2:0] {IDLE, POWERUP, ISSUE, WAIT, CHECK, GAP, DONE, ERROR} state_t;
  typedef enum logic [5:0] {
    CMD0 = 6'd0, CMD2 = 6'd2, CMD3 = 6'd3, CMD7 = 6'd7,
    CMD8 = 6'd8, CMD9 = 6'd9, ACMD41 = 6'd41, CMD55 = 6'd55
  } step_t;
`ifdef SD_INIT_CSD_EN
  localparam int RW = 120;
  localparam step_t AFTER_RCA = CMD9;
  logic unused_resp;
  assign unused_resp = ^cmdRespIndex;
`else
  localparam int RW = 32;
  localparam step_t AFTER_RCA = CMD7;
  logic unused_resp;
  assign unused_resp = ^{cmdRespIndex, cmdRespArgument[119:32]};
`endif
  state_t state, state_n;
  step_t step, step_n, step_nxt;
  logic [31:0] cnt, retry, lim;
  logic [3:0] code_n;
  logic hcs, tmo, idle_like;
  logic [RW-1:0] resp;
  assign idle_like = state == IDLE || state == DONE || state == ERROR;
  assign busy = !idle_like;
  assign done = state == DONE;
  assign error = state == ERROR;
  assign cmdStart = state == ISSUE;
  assign cmdIndex = step;
  assign cmdArgument = step == CMD8 ? 32'h0000_01AA :
                       step == ACMD41 ? {1'b0, hcs, 6'b0, 24'hFF8000} :
                       (step == CMD9 || step == CMD7) ? {rca, 16'h0} : 32'h0;
  assign lim = state == POWERUP ? POWERUP_CYCLES - 32'd1 : GAP_CYCLES - 32'd1;
  always_comb begin
    state_n = state;
    step_n = step;
    code_n = 4'd0;
    step_nxt = step;
    case (step)
      CMD0:    step_nxt = CMD8;
      CMD8:    step_nxt = CMD55;
      CMD55:   step_nxt = ACMD41;
      ACMD41:  step_nxt = resp[31] ? CMD2 : CMD55;
      CMD2:    step_nxt = CMD3;
      CMD3:    step_nxt = AFTER_RCA;
      CMD9:    step_nxt = CMD7;
      default: step_nxt = step;
    endcase
    case (step)
      CMD8:    code_n = (!tmo && resp[7:0] != 8'hAA) ? 4'd1 : 4'd0;
      ACMD41:  code_n = (!resp[31] && retry + 32'd1 == ACMD41_RETRIES) ? 4'd2 : 4'd0;
      CMD3:    code_n = resp[31:16] == 16'h0 ? 4'd4 : 4'd0;
      default: code_n = 4'd0;
    endcase
    // CMD0 never answers and a silent CMD8 just means a v1 card
    if (tmo && step != CMD0 && step != CMD8) code_n = 4'd3;
    case (state)
      IDLE, DONE, ERROR: begin
        state_n = beginInit ? POWERUP : IDLE;
        step_n = beginInit ? CMD0 : step;
      end
      POWERUP: state_n = cnt == lim ? ISSUE : POWERUP;
      ISSUE:   state_n = WAIT;
      WAIT:    state_n = cmdFinished ? CHECK : WAIT;
      CHECK: begin
        state_n = code_n != 4'd0 ? ERROR : step == CMD7 ? DONE : GAP;
        step_n = step_nxt;
      end
      GAP:     state_n = cnt == lim ? ISSUE : GAP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge sdClock) begin
    if (!reset) begin
      state <= IDLE;
      step <= CMD0;
      cnt <= '0;
      retry <= '0;
      errorCode <= '0;
      ocr <= '0;
      rca <= '0;
      csd <= '0;
      highCapacity <= 1'b0;
      hcs <= 1'b0;
      tmo <= 1'b0;
      resp <= '0;
    end else begin
      state <= state_n;
      step <= step_n;
      cnt <= (state_n == state && (state == POWERUP || state == GAP)) ? cnt + 32'd1 : '0;
      if (idle_like && beginInit) begin
        retry <= '0;
        errorCode <= '0;
      end
      if (state == WAIT && cmdFinished) begin
        tmo <= cmdTimeout;
        resp <= cmdRespArgument[RW-1:0];
      end
      if (state == CHECK) begin
        if (code_n != 4'd0) errorCode <= code_n;
        if (step == CMD8) hcs <= !tmo;
        if (step == ACMD41 && !tmo && resp[31]) begin
          ocr <= resp[31:0];
          highCapacity <= resp[30] & hcs;
        end
        if (step == ACMD41 && !tmo && !resp[31]) retry <= retry + 32'd1;
        if (step == CMD3 && code_n == 4'd0) rca <= resp[31:16];
`ifdef SD_INIT_CSD_EN
        if (step == CMD9 && !tmo) csd <= resp;
`endif
      end
    end
  end
endmodule

// File: tb/tb_sd_init_sequencer.sv
// tb_sd_init_sequencer: table-driven card scenarios plus reset/begin corner sequences
module tb_sd_init_sequencer;
  localparam int PU = 80, GAP = 8, RET = 4;
`ifdef SD_INIT_CSD_EN
  localparam int CSD_N = 1;
  localparam logic [119:0] CSD_V = 120'hABC;
`else
  localparam int CSD_N = 0;
  localparam logic [119:0] CSD_V = 120'h0;
`endif
  logic sdClock = 1'b0, reset = 1'b0, beginInit = 1'b0;
  logic busy, done, error, highCapacity, cmdStart;
  logic [3:0] errorCode;
  logic [31:0] ocr, cmdArgument;
  logic [15:0] rca;
  logic [119:0] csd;
  logic [5:0] cmdIndex;
  logic cmdFinished = 1'b0, cmdTimeout = 1'b0;
  logic [5:0] cmdRespIndex = 6'd0;
  logic [119:0] cmdRespArgument = 120'd0;
  int cyc = 0, checks = 0, errors = 0;

  sd_init_sequencer #(.POWERUP_CYCLES(PU), .GAP_CYCLES(GAP), .ACMD41_RETRIES(RET)) dut (
    .sdClock(sdClock), .reset(reset), .beginInit(beginInit), .busy(busy), .done(done),
    .error(error), .errorCode(errorCode), .highCapacity(highCapacity), .ocr(ocr), .rca(rca),
    .csd(csd), .cmdStart(cmdStart), .cmdIndex(cmdIndex), .cmdArgument(cmdArgument),
    .cmdFinished(cmdFinished), .cmdTimeout(cmdTimeout), .cmdRespIndex(cmdRespIndex),
    .cmdRespArgument(cmdRespArgument));

  always #5 sdClock = ~sdClock;
  always @(posedge sdClock) cyc <= cyc + 1;

  typedef struct {
    logic [5:0] tmo_idx;
    logic [7:0] echo;
    int ready_try;
    logic [31:0] ready_ocr;
    logic [15:0] rca_resp;
    logic exp_done;
    logic [3:0] exp_code;
    logic exp_hc;
    int n;
    logic [127:0] seq;
    int n9;
  } vec_t;
  vec_t v[10];

  function automatic vec_t mk(logic [5:0] ti, logic [7:0] ec, int rt, logic [31:0] oc, logic [15:0] ra,
                              logic d, logic [3:0] code, logic hc, int n, logic [127:0] seq, int n9);
    vec_t r;
    r.tmo_idx = ti; r.echo = ec; r.ready_try = rt; r.ready_ocr = oc; r.rca_resp = ra;
    r.exp_done = d; r.exp_code = code; r.exp_hc = hc; r.n = n; r.seq = seq; r.n9 = n9;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    reset = 1'b0; beginInit = 1'b0; cmdFinished = 1'b0; cmdTimeout = 1'b0;
    repeat (2) @(negedge sdClock);
    reset = 1'b1;
  endtask

  task automatic kick(output int t);
    beginInit = 1'b1;
    t = cyc;
    @(negedge sdClock);
    beginInit = 1'b0;
  endtask

  // Card model: answers each command after 3 cycles, checks arguments, hold and spacing
  task automatic serve(input vec_t s, input int t_begin, input logic abort41, input logic beg_fin,
                       output logic [127:0] obs, output int nobs, output int n9,
                       output logic got_done, output logic got_err);
    int last, n41, gap;
    logic fin, first, to, hcs_exp;
    logic [5:0] idx;
    logic [31:0] arg, exp_arg;
    logic [119:0] r;
    last = t_begin; n41 = 0; fin = 0; first = 1; hcs_exp = s.tmo_idx != 6'd8;
    obs = '0; nobs = 0; n9 = 0; got_done = 0; got_err = 0;
    for (int i = 0; i < 4000 && !fin; i++) begin
      @(negedge sdClock);
      if (done || error) begin
        got_done = done; got_err = error; fin = 1;
      end else if (cmdStart) begin
        idx = cmdIndex; arg = cmdArgument;
        gap = cyc - last - 1;
        chk($sformatf("spacing before cmd%0d", idx),
            first ? (gap >= PU && gap <= PU + 2) : (gap >= GAP && gap <= GAP + 2), 1'b1);
        first = 0;
        if (idx == 6'd9) n9++;
        else begin obs = {obs[119:0], 2'b00, idx}; nobs++; end
        exp_arg = idx == 6'd8 ? 32'h1AA : idx == 6'd41 ? {1'b0, hcs_exp, 6'b0, 24'hFF8000} :
                  (idx == 6'd9 || idx == 6'd7) ? {s.rca_resp, 16'h0} : 32'h0;
        chk($sformatf("arg cmd%0d", idx), arg, exp_arg);
        if (abort41 && idx == 6'd41) fin = 1;
        else begin
          to = idx == 6'd0 || idx == s.tmo_idx;
          if (idx == 6'd41) n41++;
          r = 120'h900;
          if (idx == 6'd8) r = {112'h0, s.echo};
          if (idx == 6'd41) r = {88'h0, (s.ready_try != 0 && n41 >= s.ready_try) ? s.ready_ocr : 32'h00FF8000};
          if (idx == 6'd3) r = {88'h0, s.rca_resp, 16'h0520};
          if (idx == 6'd9) r = 120'hABC;
          repeat (3) begin
            @(negedge sdClock);
            chk($sformatf("hold cmd%0d", idx), {cmdStart, cmdIndex, cmdArgument}, {1'b0, idx, arg});
          end
          cmdFinished = 1'b1; cmdTimeout = to; cmdRespIndex = idx;
          cmdRespArgument = to ? 120'h0 : r; beginInit = beg_fin; last = cyc;
          @(negedge sdClock);
          cmdFinished = 1'b0; cmdTimeout = 1'b0; beginInit = 1'b0;
        end
      end
    end
    if (!fin) chk("serve bound expired", 1'b0, 1'b1);
  endtask

  task automatic run_vec(input int k);
    logic [127:0] obs;
    int nobs, n9, tb;
    logic gd, ge, seen;
    do_reset();
    kick(tb);
    serve(v[k], tb, 1'b0, 1'b0, obs, nobs, n9, gd, ge);
    chk($sformatf("v%0d outcome", k), {gd, ge}, {v[k].exp_done, !v[k].exp_done});
    chk($sformatf("v%0d errorCode", k), errorCode, v[k].exp_code);
    chk($sformatf("v%0d cmd seq", k), obs, v[k].seq);
    chk($sformatf("v%0d cmd count", k), nobs, v[k].n);
    chk($sformatf("v%0d cmd9 count", k), n9, v[k].n9);
    chk($sformatf("v%0d busy at end", k), busy, 1'b0);
    if (v[k].exp_done) begin
      chk($sformatf("v%0d highCapacity", k), highCapacity, v[k].exp_hc);
      chk($sformatf("v%0d ocr", k), ocr, v[k].ready_ocr);
      chk($sformatf("v%0d rca", k), rca, v[k].rca_resp);
      chk($sformatf("v%0d csd", k), csd, CSD_V);
    end
    @(negedge sdClock);
    chk($sformatf("v%0d pulse width", k), {done, error}, 2'b00);
    seen = 0;
    repeat (20) begin
      @(negedge sdClock);
      seen |= cmdStart;
    end
    chk($sformatf("v%0d no cmdStart after end", k), seen, 1'b0);
    chk($sformatf("v%0d errorCode held", k), errorCode, v[k].exp_code);
  endtask

  initial begin
    logic [127:0] obs;
    int nobs, n9, tb, tdummy;
    logic gd, ge;
    v[0] = mk(6'h3F, 8'hAA, 3, 32'hC0FF8000, 16'h1234, 1, 0, 1, 11, 88'h00_08_37_29_37_29_37_29_02_03_07, CSD_N);
    v[1] = mk(6'd8, 8'hAA, 1, 32'h80FF8000, 16'hBEEF, 1, 0, 0, 7, 56'h00_08_37_29_02_03_07, CSD_N);
    v[2] = mk(6'd8, 8'hAA, 2, 32'hC0FF8000, 16'h0001, 1, 0, 0, 9, 72'h00_08_37_29_37_29_02_03_07, CSD_N);
    v[3] = mk(6'h3F, 8'h55, 1, 32'hC0FF8000, 16'h1234, 0, 1, 0, 2, 16'h00_08, 0);
    v[4] = mk(6'h3F, 8'hAA, 0, 32'h0, 16'h1234, 0, 2, 0, 10, 80'h00_08_37_29_37_29_37_29_37_29, 0);
    v[5] = mk(6'h3F, 8'hAA, 1, 32'hC0FF8000, 16'h0000, 0, 4, 0, 6, 48'h00_08_37_29_02_03, 0);
    v[6] = mk(6'h3F, 8'hAA, 4, 32'h80FF8000, 16'hFFFF, 1, 0, 0, 13, 104'h00_08_37_29_37_29_37_29_37_29_02_03_07, CSD_N);
    v[7] = mk(6'd2, 8'hAA, 1, 32'hC0FF8000, 16'h1234, 0, 3, 0, 5, 40'h00_08_37_29_02, 0);
    v[8] = mk(6'd7, 8'hAA, 1, 32'hC0FF8000, 16'h4321, 0, 3, 0, 7, 56'h00_08_37_29_02_03_07, CSD_N);
    v[9] = mk(6'd55, 8'hAA, 1, 32'hC0FF8000, 16'h1234, 0, 3, 0, 3, 24'h00_08_37, 0);
    repeat (3) @(negedge sdClock);
    chk("reset flags", {busy, done, error, cmdStart, highCapacity}, 5'b0);
    chk("reset errorCode", errorCode, 4'd0);
    chk("reset ocr/rca", {ocr, rca}, 48'h0);
    chk("reset csd", csd, 120'h0);
    chk("reset cmd", {cmdIndex, cmdArgument}, 38'h0);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) run_vec(k);

    // Stray cmdFinished in IDLE, begin repeated while busy, reset during ACMD41 wait
    do_reset();
    cmdFinished = 1'b1; cmdTimeout = 1'b1;
    @(negedge sdClock);
    cmdFinished = 1'b0; cmdTimeout = 1'b0;
    @(negedge sdClock);
    chk("stray finish in idle", {busy, cmdStart}, 2'b00);
    kick(tb);
    chk("busy after begin", busy, 1'b1);
    repeat (10) @(negedge sdClock);
    beginInit = 1'b1; cmdFinished = 1'b1; cmdTimeout = 1'b1;
    @(negedge sdClock);
    beginInit = 1'b0; cmdFinished = 1'b0; cmdTimeout = 1'b0;
    serve(v[0], tb, 1'b1, 1'b0, obs, nobs, n9, gd, ge);
    chk("seq up to first acmd41", obs, 32'h00_08_37_29);
    @(negedge sdClock);
    reset = 1'b0;
    @(negedge sdClock);
    chk("abort busy/cmdStart", {busy, cmdStart}, 2'b00);
    chk("abort rca/ocr", {rca, ocr}, 48'h0);
    reset = 1'b1;
    @(negedge sdClock);
    kick(tb);
    serve(v[0], tb, 1'b0, 1'b1, obs, nobs, n9, gd, ge);
    chk("restart outcome", {gd, ge}, 2'b10);
    chk("restart seq", obs, v[0].seq);
    chk("restart rca/hc", {rca, highCapacity}, {16'h1234, 1'b1});

    // errorCode persists until the next begin, then clears
    do_reset();
    kick(tb);
    serve(v[3], tb, 1'b0, 1'b0, obs, nobs, n9, gd, ge);
    repeat (10) @(negedge sdClock);
    chk("errorCode persists", errorCode, 4'd1);
    kick(tdummy);
    chk("errorCode cleared by begin", {errorCode, busy}, {4'd0, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
